sdram_traffic_checker: RTL

- Synthesisable, parametrised successor to the controller test fixture; replaces hand-written stimulus with on-chip self-checking traffic.
- Sits between user logic and SDRAM_Controller, driving its rd/wt trigger/address/data ports.
- On `start`, writes a pattern over an address window, then reads the window back and compares each word.
- Reports pass/fail, error count, first failing word and handshake timeouts.

---
 rtl/sdram_traffic_checker.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sdram_traffic_checker.sv
// Self-checking SDRAM traffic generator: writes a pattern over an address window,
// reads it back through the controller handshake and reports mismatches and timeouts.
module sdram_traffic_checker #(
    parameter int          ADR_W   = 24,
    parameter int          DATA_W  = 16,
    parameter logic [15:0] SEED    = 16'hA5C3,
    parameter int          TMO_CYC = 1023,
    parameter int          ERR_W   = 16
) (
    input  logic              global_CLK,
    input  logic              global_RST,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADR_W-1:0]  adr_first,
    input  logic [ADR_W-1:0]  adr_last,
    output logic              rd_startTrig,
    output logic [ADR_W-1:0]  RD_ADR,
    input  logic              rd_busyFlag,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              wt_startTrig,
    output logic [ADR_W-1:0]  WT_ADR,
    output logic [DATA_W-1:0] WT_DATA,
    input  logic              wt_busyFlag,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADR_W-1:0]  first_err_adr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got,
    output logic [3:0]        Status
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WR_REQ = 4'd1,
        WR_ACK = 4'd2,
        WR_END = 4'd3,
        RD_REQ = 4'd4,
        RD_ACK = 4'd5,
        RD_END = 4'd6,
        CHECK  = 4'd7,
        DONE   = 4'd8
    } state_t;

    localparam int                CNT_W   = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0]  TMO_LIM = CNT_W'(TMO_CYC);
    localparam logic [DATA_W-1:0] SEED_D  = DATA_W'(SEED);

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]       m,
                                                  input logic [ADR_W-1:0] a,
                                                  input logic [ADR_W-1:0] base);
        logic [ADR_W-1:0]  k;
        logic [DATA_W-1:0] a_d;
        k   = a - base;
        a_d = DATA_W'(a);
        case (m)
            2'd0:    return a_d;
            2'd1:    return ~a_d;
            2'd2:    return DATA_W'(1) << (k % ADR_W'(DATA_W));
            default: return a_d ^ SEED_D;
        endcase
    endfunction

    state_t            state, state_nxt;
    logic [ADR_W-1:0]  cur_adr, adr_first_q, adr_last_q;
    logic [1:0]        mode_q;
    logic              empty_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_fire;

    logic              counting, tmo_hit, at_last, start_ok, mismatch;
    logic [DATA_W-1:0] exp_data;

    assign counting = (state inside {WR_REQ, WR_ACK, WR_END, RD_REQ, RD_ACK, RD_END});
    assign tmo_hit  = counting && (tmo_cnt == TMO_LIM);
    assign at_last  = (cur_adr == adr_last_q);
    assign start_ok = start && (state == IDLE || state == DONE);
    assign exp_data = pattern(mode_q, cur_adr, adr_first_q);
    assign mismatch = (rd_data_q != exp_data);

    // Triggers are combinational so they vanish the instant reset forces IDLE.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        wt_startTrig = 1'b0;
        rd_startTrig = 1'b0;
        tmo_fire     = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_nxt = (adr_first > adr_last) ? DONE : WR_REQ;
            WR_REQ: begin
                if (!wt_busyFlag) begin
                    wt_startTrig = 1'b1;
                    state_nxt    = WR_ACK;
                end else if (tmo_hit) tmo_fire = 1'b1;
            end
            WR_ACK: if (wt_busyFlag) state_nxt = WR_END; else if (tmo_hit) tmo_fire = 1'b1;
            WR_END: if (!wt_busyFlag) state_nxt = at_last ? RD_REQ : WR_REQ;
                    else if (tmo_hit) tmo_fire = 1'b1;
            RD_REQ: begin
                if (!rd_busyFlag) begin
                    rd_startTrig = 1'b1;
                    state_nxt    = RD_ACK;
                end else if (tmo_hit) tmo_fire = 1'b1;
            end
            RD_ACK: if (rd_busyFlag) state_nxt = RD_END; else if (tmo_hit) tmo_fire = 1'b1;
            RD_END: if (!rd_busyFlag) state_nxt = CHECK; else if (tmo_hit) tmo_fire = 1'b1;
            CHECK:  state_nxt = at_last ? DONE : RD_REQ;
            default: state_nxt = IDLE;
        endcase
        if (tmo_fire) state_nxt = DONE;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge global_CLK or posedge global_RST) begin
        if (global_RST) begin
            state         <= IDLE;
            cur_adr       <= '0;
            adr_first_q   <= '0;
            adr_last_q    <= '0;
            mode_q        <= '0;
            empty_q       <= 1'b0;
            rd_data_q     <= '0;
            tmo_cnt       <= '0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_adr <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= (!counting || state_nxt != state) ? '0 : tmo_cnt + CNT_W'(1);
            if (tmo_fire) timeout <= 1'b1;
            case (state)
                IDLE, DONE: if (start_ok) begin
                    cur_adr       <= adr_first;
                    adr_first_q   <= adr_first;
                    adr_last_q    <= adr_last;
                    mode_q        <= mode;
                    empty_q       <= (adr_first > adr_last);
                    timeout       <= 1'b0;
                    err_count     <= '0;
                    first_err_adr <= '0;
                    first_err_exp <= '0;
                    first_err_got <= '0;
                end
                WR_END: if (!wt_busyFlag) cur_adr <= at_last ? adr_first_q : cur_adr + ADR_W'(1);
                RD_END: if (!rd_busyFlag) rd_data_q <= RD_DATA;
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                        if (err_count == '0) begin
                            first_err_adr <= cur_adr;
                            first_err_exp <= exp_data;
                            first_err_got <= rd_data_q;
                        end
                    end
                    if (!at_last) cur_adr <= cur_adr + ADR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign WT_ADR  = cur_adr;
    assign RD_ADR  = cur_adr;
    assign WT_DATA = (state inside {WR_REQ, WR_ACK, WR_END}) ? exp_data : '0;
    assign busy    = !(state == IDLE || state == DONE);
    assign done    = (state == DONE);
    assign pass    = done && (err_count == '0) && !timeout && !empty_q;
    assign Status  = state;

endmodule
